mux_scan_ctrl: RTL
==================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 4, sets the clock cycles spent on each select value; legal range 1..16.
REQ-002 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, asynchronous active-high reset.
REQ-004 Port start, input, 1, begins a scan frame when sampled high in IDLE.
REQ-005 Port cont, input, 1, continuous mode: when high at frame hand-off, the next frame starts with no return to IDLE.
REQ-006 Port abort, input, 1, cancels a frame in progress.
REQ-007 Port mux_out, input, 1, output of the downstream 4:1 mux for the current sel.
REQ-008 Port sel, output, 2, registered select driving the mux.
REQ-009 Port data, output, 4, captured frame; data[n] = mux_out sampled while sel = n.
REQ-010 Port valid, output, 1, data holds a completed frame.
REQ-011 Port ready, input, 1, consumer accepts data when valid & ready.
REQ-012 Port busy, output, 1, high in SCAN and OUT states.
REQ-013 Port frame_cnt, output, 8, count of accepted frames.

Function
REQ-014 FSM states: IDLE, SCAN, OUT; state, sel, dwell counter, capture buffer and all outputs are registers.
REQ-015 IDLE: sel = 0, valid = 0, busy = 0; start = 1 -> SCAN with sel = 0 and dwell count = 0.
REQ-016 SCAN: dwell count increments every cycle; at count = DWELL-1, mux_out is captured into buffer bit [sel], and the count returns to 0.
REQ-017 SCAN, capture with sel < 3: sel increments by 1.
REQ-018 SCAN, capture with sel = 3: data loads {mux_out, buffer[2:0]} and valid goes high on that same edge; next state is OUT; sel holds at 3.
REQ-019 Latency: valid rises exactly 4*DWELL clock edges after the edge that samples start.
REQ-020 OUT: data and valid remain stable while ready = 0, with no timeout.
REQ-021 OUT with ready = 1: valid clears and frame_cnt increments.
REQ-022 After acceptance in OUT: if cont = 1, next state is SCAN with sel = 0 and count = 0; otherwise next state is IDLE.
REQ-023 frame_cnt wraps from 255 to 0.
REQ-024 abort = 1 in SCAN: next state is IDLE, the partial buffer is discarded, valid stays 0, and frame_cnt is unchanged.
REQ-025 abort in OUT or IDLE is ignored; abort has priority over capture in the same cycle.
REQ-026 start is ignored outside IDLE.
REQ-027 start and abort high together in IDLE: abort is ignored and the frame starts.
REQ-028 DWELL = 1: one capture per cycle, and sel steps every cycle.

Reset
REQ-029 rst = 1 forces, asynchronously and independent of clk: state = IDLE, sel = 0, data = 0, valid = 0, busy = 0, frame_cnt = 0, dwell count = 0, buffer = 0.
REQ-030 rst asserted mid-frame or while valid = 1 drops the frame; no valid pulse follows reset release.
REQ-031 After rst deasserts, the first start sampled on a rising edge begins a normal frame.

Verification
REQ-032 DWELL=4, static channel values a=1 b=0 c=1 d=1, start for 1 cycle, ready=1 -> sel steps 0,1,2,3 every 4 cycles; valid rises 16 cycles after start with data=4'b1101; frame_cnt=1; returns to IDLE.
REQ-033 Same stimulus with ready=0 for 10 cycles after valid -> data=4'b1101 and valid held for all 10 cycles; acceptance on the 11th cycle; frame_cnt=1.
REQ-034 cont=1, ready=1, channel values changing to 4'b0110 after frame 1 -> back-to-back frames with 4'b1101 then 4'b0110, no IDLE cycle between them, frame_cnt=2.
REQ-035 abort pulsed while sel=2 -> IDLE on the next cycle, valid never asserts, frame_cnt unchanged; a new start completes normally.
REQ-036 rst asserted asynchronously (between edges) while sel=1 -> all outputs zero immediately; no valid after release.
REQ-037 256 accepted frames in cont mode -> frame_cnt reads 0 after the 256th acceptance.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select, samples mux_out per channel after a dwell,
// and hands the captured 4-bit frame to a valid/ready consumer.
module mux_scan_ctrl #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       abort,
    input  logic       mux_out,
    input  logic       ready,
    output logic [1:0] sel,
    output logic [3:0] data,
    output logic       valid,
    output logic       busy,
    output logic [7:0] frame_cnt
);
    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;
    localparam logic [3:0] LAST = 4'(DWELL - 1);
    state_t     state;
    logic [3:0] cnt;
    logic [2:0] buffer;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 2'd0;
            cnt       <= 4'd0;
            buffer    <= 3'd0;
            data      <= 4'd0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= SCAN;
                    busy  <= 1'b1;
                    sel   <= 2'd0;
                    cnt   <= 4'd0;
                end
                SCAN: if (abort) begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    sel    <= 2'd0;
                    cnt    <= 4'd0;
                    buffer <= 3'd0;
                end else if (cnt == LAST) begin
                    cnt <= 4'd0;
                    if (sel != 2'd3) begin
                        buffer[sel] <= mux_out;
                        sel         <= sel + 2'd1;
                    end else begin
                        data  <= {mux_out, buffer};
                        valid <= 1'b1;
                        state <= OUT;
                    end
                end else begin
                    cnt <= cnt + 4'd1;
                end
                OUT: if (ready) begin
                    // continuous mode restarts the scan on the acceptance edge itself
                    valid     <= 1'b0;
                    frame_cnt <= frame_cnt + 8'd1;
                    sel       <= 2'd0;
                    cnt       <= 4'd0;
                    busy      <= cont;
                    state     <= cont ? SCAN : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
